shift_epoch_ctrl: RTL and testbench
===================================

Name: shift_epoch_ctrl

Overview:
- Timing and epoch generator that sits directly upstream of the shift-marking SRAM sweeper.
- Emits the periodic one-cycle `watchdog_signal` that restarts each memory sweep.
- Supplies the `cur_bucket` / `cur_loop` pair the sweeper latches and applies to every SRAM line on the next pass.
- Bucket advances once per watchdog and wraps into a loop increment, giving a sliding-window epoch counter for the Bloom buckets.

Parameters:
- SRAM_DATA_WIDTH, 72, SRAM line width; used only to derive NUM_BUCKETS.
- NUM_BITS_BUCKET, 4, bits per bucket.
- NUM_BITS_RESERVED, 16, reserved control bits per line; BLOOM_POS = NUM_BITS_RESERVED.
- NUM_BUCKETS, (SRAM_DATA_WIDTH-NUM_BITS_RESERVED)/NUM_BITS_BUCKET = 14, buckets per line.
- BITS_SHIFT, log2(NUM_BUCKETS) = 4, bucket index width (codebase ceil-log2).
- TIMER_WIDTH, 32, period counter width.
- DEFAULT_PERIOD, 1000000, watchdog period in clk cycles after reset.
- MIN_PERIOD, 16, floor applied to any programmed period.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run timer; low = IDLE
- pause  in  1  freeze countdown, outputs held
- period_wr  in  1  one-cycle strobe, load period_in
- period_in  in  TIMER_WIDTH  new period in cycles
- watchdog_signal  out  1  one-cycle sweep-restart pulse
- cur_bucket  out  BITS_SHIFT  current bucket index, 0..NUM_BUCKETS-1
- cur_loop  out  BLOOM_POS-BITS_SHIFT (12)  epoch loop count
- epoch_wrap  out  1  one-cycle pulse when cur_loop wraps to 0
- busy  out  1  high in RUN or HOLD

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-high `reset`, sampled on posedge clk.
- Reset values:
  - state = IDLE
  - watchdog_signal = 0, epoch_wrap = 0, busy = 0
  - cur_bucket = 0, cur_loop = 0
  - period_reg = DEFAULT_PERIOD, count = 0
- All outputs are registered.
- Period write:
  - When period_wr = 1, period_reg <= max(period_in, MIN_PERIOD). This applies in any state.
  - The new value takes effect at the next reload only; the interval in progress is not truncated.
- States:
  - IDLE:
    - On enable = 1, go to RUN with count <= period_reg-1.
    - No pulse is issued on entry; the first pulse occurs period_reg cycles after entry.
  - RUN:
    - pause = 1 -> HOLD.
    - enable = 0 -> IDLE. count is cleared; cur_bucket and cur_loop are held, not cleared.
    - Else if count == 0: for one cycle set watchdog_signal = 1, count <= period_reg-1 (using the value written that cycle if period_wr = 1), and apply the bucket advance below.
    - Else count <= count-1.
  - HOLD:
    - count frozen.
    - pause = 0 -> RUN.
    - enable = 0 -> IDLE.
    - A terminal count is never fired from HOLD.
- Bucket advance (registered in the same cycle watchdog_signal rises, so the sweeper sees new values no later than the pulse):
  - If cur_bucket == NUM_BUCKETS-1: cur_bucket <= 0 and cur_loop <= cur_loop+1 (modulo 2^12).
  - If cur_loop also goes 4095 -> 0, epoch_wrap = 1 for that cycle.
  - Otherwise cur_bucket <= cur_bucket+1.
- Pulse spacing: consecutive watchdog_signal pulses are exactly period_reg cycles apart while in RUN.
- Simultaneous events, resolved in this priority order: reset > enable = 0 > pause = 1 > terminal count.
  - pause asserted in the terminal cycle suppresses the pulse. The pulse fires on the first RUN cycle after unpause.
- Width rules: count and period_reg are TIMER_WIDTH unsigned. period_in below MIN_PERIOD is clamped, and this includes 0.
- Reset mid-interval: any pending pulse is cancelled and all state returns to reset values on the next edge.

Optional Feature:
- Macro: SHIFT_EPOCH_STATS_EN.
- When defined, add these outputs:
  - fire_count (out, 32): counts watchdog_signal pulses; saturates at 0xFFFFFFFF; reset 0.
  - late_sweep (out, 1): sticky; set when a pulse fires while input sweep_busy (in, 1) is high, i.e. the previous sweep has not finished; reset 0.
- When undefined, these ports and their logic are absent, and the core behaviour is identical.

Test Plan:
- Reset then enable = 1 with period_wr period_in = 20 in the same cycle -> first watchdog_signal exactly 20 cycles after the RUN entry (DEFAULT_PERIOD is ignored because the write precedes the reload); thereafter pulses every 20 cycles; cur_bucket 1, 2, 3...
- 14 pulses at period 20 -> cur_bucket 13 -> 0 and cur_loop 0 -> 1 on the 14th pulse; epoch_wrap stays 0.
- Preload: run until cur_loop = 4095 and cur_bucket = 13, then the next pulse -> both go to 0 and epoch_wrap = 1 for one cycle.
- period_in = 3 -> period_reg = 16. Also write period_in = 50 mid-interval at period 20 -> the current gap stays 20, the next gap is 50.
- pause high 7 cycles at count = 5 -> pulse delayed exactly 7 cycles. pause in the terminal cycle -> no pulse until unpause.
- enable = 0 mid-count, then enable = 1 -> the next pulse is a full period later and cur_bucket/cur_loop are retained. reset mid-count -> all outputs 0 and period back to DEFAULT_PERIOD.

Source files
------------

// File: rtl/shift_epoch_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_epoch_ctrl_if
//
// Purpose: groups the control and epoch signals that pass between the epoch
// generator (slave side) and whoever drives it (master side: a CSR block, the
// sweeper wrapper or a testbench).
//
// Signals:
//   enable          master -> slave  run the period timer; low parks it in idle
//   pause           master -> slave  freeze the countdown, outputs held
//   period_wr       master -> slave  one-cycle strobe, load period_in
//   period_in       master -> slave  new period in clk cycles
//   watchdog_signal slave -> master  one-cycle sweep-restart pulse
//   cur_bucket      slave -> master  current bucket index, 0..NUM_BUCKETS-1
//   cur_loop        slave -> master  epoch loop count
//   epoch_wrap      slave -> master  one-cycle pulse when cur_loop wraps to 0
//   busy            slave -> master  high while running or holding
//
// Optional (SHIFT_EPOCH_STATS_EN defined):
//   sweep_busy      master -> slave  the sweeper is still inside a pass
//   fire_count      slave -> master  saturating count of watchdog pulses
//   late_sweep      slave -> master  sticky: a pulse fired while sweep_busy
// -----------------------------------------------------------------------------
interface shift_epoch_ctrl_if #(
    parameter int unsigned TIMER_WIDTH = 32,
    parameter int unsigned BITS_SHIFT  = 4,
    parameter int unsigned LOOP_WIDTH  = 12
);
    logic                   enable;
    logic                   pause;
    logic                   period_wr;
    logic [TIMER_WIDTH-1:0] period_in;

    logic                   watchdog_signal;
    logic [BITS_SHIFT-1:0]  cur_bucket;
    logic [LOOP_WIDTH-1:0]  cur_loop;
    logic                   epoch_wrap;
    logic                   busy;

`ifdef SHIFT_EPOCH_STATS_EN
    logic                   sweep_busy;
    logic [31:0]            fire_count;
    logic                   late_sweep;

    modport master (
        output enable, pause, period_wr, period_in, sweep_busy,
        input  watchdog_signal, cur_bucket, cur_loop, epoch_wrap, busy, fire_count, late_sweep
    );

    modport slave (
        input  enable, pause, period_wr, period_in, sweep_busy,
        output watchdog_signal, cur_bucket, cur_loop, epoch_wrap, busy, fire_count, late_sweep
    );
`else
    modport master (
        output enable, pause, period_wr, period_in,
        input  watchdog_signal, cur_bucket, cur_loop, epoch_wrap, busy
    );

    modport slave (
        input  enable, pause, period_wr, period_in,
        output watchdog_signal, cur_bucket, cur_loop, epoch_wrap, busy
    );
`endif

endinterface

// File: rtl/shift_epoch_ctrl.sv
// -----------------------------------------------------------------------------
// shift_epoch_ctrl
//
// Purpose: timing and epoch generator for the shift-marking SRAM sweeper.
// A programmable down-counter emits a one-cycle watchdog_signal every
// period_reg cycles while running. Each pulse advances cur_bucket; when the
// bucket index wraps past NUM_BUCKETS-1 the loop counter increments, and when
// the loop counter itself wraps epoch_wrap pulses. The sweeper latches
// cur_bucket/cur_loop at the pulse and applies them on the next pass.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of shift_epoch_ctrl_if (control in, epoch state out)
//
// Optional build macro: SHIFT_EPOCH_STATS_EN adds fire_count / late_sweep
// outputs and the sweep_busy input. With the macro undefined the core
// behaviour is identical and those signals do not exist.
//
// Event priority within a cycle: reset > enable low > pause > terminal count.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module shift_epoch_ctrl #(
    parameter int unsigned SRAM_DATA_WIDTH   = 72,
    parameter int unsigned NUM_BITS_BUCKET   = 4,
    parameter int unsigned NUM_BITS_RESERVED = 16,
    parameter int unsigned TIMER_WIDTH       = 32,
    parameter int unsigned DEFAULT_PERIOD    = 1000000,
    parameter int unsigned MIN_PERIOD        = 16
) (
    input logic               clk,
    input logic               reset,
    shift_epoch_ctrl_if.slave bus
);

    localparam int unsigned BLOOM_POS   = NUM_BITS_RESERVED;
    localparam int unsigned NUM_BUCKETS = (SRAM_DATA_WIDTH - NUM_BITS_RESERVED) / NUM_BITS_BUCKET;
    localparam int unsigned BITS_SHIFT  = $clog2(NUM_BUCKETS);
    localparam int unsigned LOOP_WIDTH  = BLOOM_POS - BITS_SHIFT;

    localparam logic [TIMER_WIDTH-1:0] MinPeriod     = TIMER_WIDTH'(MIN_PERIOD);
    localparam logic [TIMER_WIDTH-1:0] DefaultPeriod = TIMER_WIDTH'(DEFAULT_PERIOD);
    localparam logic [TIMER_WIDTH-1:0] TimerOne      = TIMER_WIDTH'(1);
    localparam logic [BITS_SHIFT-1:0]  LastBucket    = BITS_SHIFT'(NUM_BUCKETS - 1);
    localparam logic [BITS_SHIFT-1:0]  BucketOne     = BITS_SHIFT'(1);
    localparam logic [LOOP_WIDTH-1:0]  LoopOne       = LOOP_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic [TIMER_WIDTH-1:0] period_q, period_d;
    logic [BITS_SHIFT-1:0]  bucket_q, bucket_d;
    logic [LOOP_WIDTH-1:0]  loop_q, loop_d;
    logic                   watchdog_q, watchdog_d;
    logic                   wrap_q, wrap_d;
    logic                   busy_q, busy_d;

    logic [TIMER_WIDTH-1:0] period_clamped;
    logic                   fire;

    // Any write is floored at MinPeriod, including a write of zero.
    assign period_clamped = (bus.period_in < MinPeriod) ? MinPeriod : bus.period_in;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        bucket_d   = bucket_q;
        loop_d     = loop_q;
        watchdog_d = 1'b0;
        wrap_d     = 1'b0;
        fire       = 1'b0;

        // A write in the same cycle as a reload is seen by that reload; an
        // interval already in progress keeps its loaded count.
        period_d = bus.period_wr ? period_clamped : period_q;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StRun;
                    count_d = period_d - TimerOne;
                end
            end

            StRun: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (bus.pause) begin
                    // Count is not touched, so a terminal count is suppressed.
                    state_d = StHold;
                end else if (count_q == '0) begin
                    fire    = 1'b1;
                    count_d = period_d - TimerOne;
                end else begin
                    count_d = count_q - TimerOne;
                end
            end

            StHold: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (!bus.pause) begin
                    // The release cycle counts as a running cycle, so the
                    // pulse slips by exactly the number of paused cycles.
                    // A parked terminal count waits for a real run cycle.
                    state_d = StRun;
                    if (count_q != '0) begin
                        count_d = count_q - TimerOne;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase

        // Epoch advance lands on the same edge that raises watchdog_signal.
        if (fire) begin
            watchdog_d = 1'b1;
            if (bucket_q == LastBucket) begin
                bucket_d = '0;
                loop_d   = loop_q + LoopOne;
                wrap_d   = (loop_q == '1);
            end else begin
                bucket_d = bucket_q + BucketOne;
            end
        end

        busy_d = (state_d != StIdle);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            period_q   <= DefaultPeriod;
            bucket_q   <= '0;
            loop_q     <= '0;
            watchdog_q <= 1'b0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            bucket_q   <= bucket_d;
            loop_q     <= loop_d;
            watchdog_q <= watchdog_d;
            wrap_q     <= wrap_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.watchdog_signal = watchdog_q;
    assign bus.cur_bucket      = bucket_q;
    assign bus.cur_loop        = loop_q;
    assign bus.epoch_wrap      = wrap_q;
    assign bus.busy            = busy_q;

`ifdef SHIFT_EPOCH_STATS_EN
    // ------------------------------------------------------------------------
    // Sweep statistics
    // ------------------------------------------------------------------------
    logic [31:0] fire_count_q, fire_count_d;
    logic        late_q, late_d;

    always_comb begin
        fire_count_d = fire_count_q;
        if (fire && (fire_count_q != '1)) begin
            fire_count_d = fire_count_q + 32'd1;
        end
        // A pulse while the sweeper is still busy means a pass was overrun.
        late_d = late_q | (fire & bus.sweep_busy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_count_q <= '0;
            late_q       <= 1'b0;
        end else begin
            fire_count_q <= fire_count_d;
            late_q       <= late_d;
        end
    end

    assign bus.fire_count = fire_count_q;
    assign bus.late_sweep = late_q;
`endif

endmodule

// File: tb/tb_shift_epoch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_epoch_ctrl
//
// Self-checking bench for shift_epoch_ctrl. A table of pulse records gives,
// for each consecutive watchdog pulse, an optional period write issued at the
// start of the interval and the expected gap/bucket/loop. Hand-written
// sequences cover pause, enable drop, loop wrap and reset mid-count.
// -----------------------------------------------------------------------------
module tb_shift_epoch_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    shift_epoch_ctrl_if bus_if ();

    shift_epoch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    typedef struct {
        bit wr;
        int pin;
        int gap;
        int bucket;
        int loop;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ticks until watchdog_signal is seen high; n = -1 if the bound expires.
    // period_wr is dropped after the first tick so a write is a single strobe.
    task automatic wait_pulse(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            bus_if.period_wr = 1'b0;
            if (bus_if.watchdog_signal === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_pulse(input string name, input int gap, input int exp_gap,
                               input int bucket, input int loop, input bit wrap);
        check({name, " gap"}, gap, exp_gap);
        check({name, " bucket"}, bus_if.cur_bucket, bucket);
        check({name, " loop"}, bus_if.cur_loop, loop);
        check({name, " wrap"}, bus_if.epoch_wrap, wrap);
    endtask

    initial begin
        int n;
        int seen;

        reset            = 1'b1;
        bus_if.enable    = 1'b0;
        bus_if.pause     = 1'b0;
        bus_if.period_wr = 1'b0;
        bus_if.period_in = '0;
`ifdef SHIFT_EPOCH_STATS_EN
        bus_if.sweep_busy = 1'b0;
`endif

        // Pulse records following the first pulse (bucket 1, loop 0).
        for (int i = 2; i <= 14; i++) begin
            vecs.push_back('{wr: 1'b0, pin: 0, gap: 20, bucket: i % 14, loop: i / 14});
        end
        vecs.push_back('{wr: 1'b1, pin: 50, gap: 20, bucket: 1, loop: 1});
        vecs.push_back('{wr: 1'b0, pin: 0,  gap: 50, bucket: 2, loop: 1});
        vecs.push_back('{wr: 1'b1, pin: 3,  gap: 50, bucket: 3, loop: 1});
        vecs.push_back('{wr: 1'b0, pin: 0,  gap: 16, bucket: 4, loop: 1});
        vecs.push_back('{wr: 1'b1, pin: 0,  gap: 16, bucket: 5, loop: 1});
        vecs.push_back('{wr: 1'b0, pin: 0,  gap: 16, bucket: 6, loop: 1});
        vecs.push_back('{wr: 1'b1, pin: 20, gap: 16, bucket: 7, loop: 1});
        vecs.push_back('{wr: 1'b0, pin: 0,  gap: 20, bucket: 8, loop: 1});

        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst watchdog", bus_if.watchdog_signal, 0);
        check("rst bucket", bus_if.cur_bucket, 0);
        check("rst loop", bus_if.cur_loop, 0);
        check("rst wrap", bus_if.epoch_wrap, 0);
        check("rst busy", bus_if.busy, 0);
        check("rst period", dut.period_q, 1000000);

        // Enable with a same-cycle period write: the write feeds the first load.
        bus_if.enable    = 1'b1;
        bus_if.period_wr = 1'b1;
        bus_if.period_in = 20;
        tick();
        bus_if.period_wr = 1'b0;
        check("entry busy", bus_if.busy, 1);
        check("entry watchdog", bus_if.watchdog_signal, 0);
        wait_pulse(40, n);
        check_pulse("first", n, 20, 1, 0, 0);

        // Table: each record starts in the cycle of the previous pulse.
        foreach (vecs[k]) begin
            if (vecs[k].wr) begin
                bus_if.period_wr = 1'b1;
                bus_if.period_in = vecs[k].pin;
            end
            wait_pulse(vecs[k].gap + 10, n);
            check_pulse($sformatf("vec%0d", k), n, vecs[k].gap, vecs[k].bucket, vecs[k].loop, 0);
        end

        // Pause 7 cycles while count = 5: pulse slips by exactly 7.
        for (int i = 0; i < 14; i++) tick();
        check("pause count", dut.count_q, 5);
        bus_if.pause = 1'b1;
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus_if.watchdog_signal === 1'b1) seen++;
        end
        bus_if.pause = 1'b0;
        check("hold busy", bus_if.busy, 1);
        check("hold no pulse", seen, 0);
        wait_pulse(30, n);
        check_pulse("pause7", n, 6, 9, 1, 0);

        // Pause in the terminal cycle: no pulse until after unpause.
        for (int i = 0; i < 19; i++) tick();
        check("term count", dut.count_q, 0);
        bus_if.pause = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.watchdog_signal === 1'b1) seen++;
        end
        bus_if.pause = 1'b0;
        check("term no pulse", seen, 0);
        wait_pulse(30, n);
        check_pulse("term unpause", n, 2, 10, 1, 0);
        wait_pulse(40, n);
        check_pulse("after term", n, 20, 11, 1, 0);

        // Enable drop mid-count keeps bucket/loop; re-enable gives a full period.
        for (int i = 0; i < 8; i++) tick();
        bus_if.enable = 1'b0;
        tick();
        check("dis busy", bus_if.busy, 0);
        check("dis bucket", bus_if.cur_bucket, 11);
        check("dis loop", bus_if.cur_loop, 1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus_if.watchdog_signal === 1'b1) seen++;
        end
        check("dis no pulse", seen, 0);
        bus_if.enable = 1'b1;
        tick();
        wait_pulse(40, n);
        check_pulse("reenable", n, 20, 12, 1, 0);

        // Preload loop 4095 / bucket 13 while idle, then take one pulse.
        bus_if.enable = 1'b0;
        tick();
        force dut.bucket_q = 4'd13;
        force dut.loop_q   = 12'd4095;
        tick();
        release dut.bucket_q;
        release dut.loop_q;
        tick();
        check("preload bucket", bus_if.cur_bucket, 13);
        check("preload loop", bus_if.cur_loop, 4095);
        bus_if.enable    = 1'b1;
        bus_if.period_wr = 1'b1;
        bus_if.period_in = 16;
        tick();
        bus_if.period_wr = 1'b0;
        wait_pulse(40, n);
        check_pulse("loop wrap", n, 16, 0, 0, 1);
        tick();
        check("wrap width", bus_if.epoch_wrap, 0);
        check("pulse width", bus_if.watchdog_signal, 0);
        wait_pulse(40, n);
        check_pulse("post wrap", n, 15, 1, 0, 0);

        // Reset mid-count: everything back to reset values.
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst watchdog", bus_if.watchdog_signal, 0);
        check("midrst bucket", bus_if.cur_bucket, 0);
        check("midrst loop", bus_if.cur_loop, 0);
        check("midrst busy", bus_if.busy, 0);
        check("midrst period", dut.period_q, 1000000);
        check("midrst count", dut.count_q, 0);

        // Default period in force: no pulse within a short window.
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.watchdog_signal === 1'b1) seen++;
        end
        check("default no pulse", seen, 0);
        check("default busy", bus_if.busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
